// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared mode encodings and channel-index width helper for scan_mux
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Channel index width, never narrower than one bit.
  function automatic int calc_cw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-channel dwell counter, 0..DWELL-1 with terminal-count flag
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] LAST = DCW'(DWELL - 1);

  logic [DCW-1:0] cnt_q;
  logic [DCW-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  // clr wins over en so a jump restarts the dwell even while held.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-channel mux with manual select and timed round-robin scan
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int CW    = calc_cw(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH*W-1:0] d,
  input  logic              mode,
  input  logic [CW-1:0]     sel,
  input  logic              sel_load,
  input  logic              hold,
  output logic [W-1:0]      out,
  output logic [CW-1:0]     cur_ch,
  output logic              out_valid,
  output logic              wrap,
  output logic              sel_err
);

  localparam logic [CW:0]   N_CH_V  = (CW + 1)'(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  logic [CW-1:0] cur_q, cur_d;
  logic [W-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic          mode_q;
  logic          primed_q;

  logic scan, mode_rise, sel_ok, advance, dc_clr, dc_en, tc;

  assign scan      = (mode == MODE_SCAN);
  assign mode_rise = scan && (mode_q == MODE_MANUAL);
  assign sel_ok    = sel_load && ({1'b0, sel} < N_CH_V);
  assign dc_clr    = !scan || mode_rise || sel_ok;
  assign dc_en     = scan && !hold;
  assign advance   = scan && !hold && tc && !mode_rise && !sel_ok;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (dc_clr),
    .en    (dc_en),
    .tc    (tc)
  );

  always_comb begin
    cur_d = cur_q;
    if (sel_ok) begin
      cur_d = sel;
    end else if (advance) begin
      cur_d = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
    end
    wrap_d  = advance && (cur_q == LAST_CH);
    err_d   = sel_load && !sel_ok;
    out_d   = d[cur_q*W +: W];
    // out lags cur_ch by one edge, so a channel change leaves one stale cycle.
    valid_d = primed_q && (cur_d == cur_q);
  end

  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (reset) begin
      cur_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      primed_q <= 1'b1;
    end
  end

  assign out       = out_q;
  assign cur_ch    = cur_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed self-checking bench for scan_mux
module tb_scan_mux;

  logic clk = 1'b0;
  logic reset;

  logic [31:0] a_d;
  logic        a_mode, a_sel_load, a_hold;
  logic [2:0]  a_sel;
  logic [3:0]  a_out;
  logic [2:0]  a_cur;
  logic        a_valid, a_wrap, a_err;

  logic [23:0] b_d;
  logic        b_mode, b_sel_load, b_hold;
  logic [2:0]  b_sel;
  logic [3:0]  b_out;
  logic [2:0]  b_cur;
  logic        b_valid, b_wrap, b_err;

  int checks = 0;
  int errors = 0;
  int exp_cur[8]  = '{6, 6, 6, 7, 7, 7, 0, 0};
  int exp_wrap[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  scan_mux #(.N_CH(8), .W(4), .DWELL(3)) u_a (
    .clk(clk), .reset(reset), .d(a_d), .mode(a_mode), .sel(a_sel),
    .sel_load(a_sel_load), .hold(a_hold), .out(a_out), .cur_ch(a_cur),
    .out_valid(a_valid), .wrap(a_wrap), .sel_err(a_err)
  );

  scan_mux #(.N_CH(6), .W(4), .DWELL(1)) u_b (
    .clk(clk), .reset(reset), .d(b_d), .mode(b_mode), .sel(b_sel),
    .sel_load(b_sel_load), .hold(b_hold), .out(b_out), .cur_ch(b_cur),
    .out_valid(b_valid), .wrap(b_wrap), .sel_err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_d = 32'h8765_4321; a_mode = 1'b0; a_sel = '0; a_sel_load = 1'b0; a_hold = 1'b0;
    b_d = 24'h65_4321;   b_mode = 1'b0; b_sel = '0; b_sel_load = 1'b0; b_hold = 1'b0;
    tick(); tick();
    chk("rst_cur", a_cur, 0);
    chk("rst_out", a_out, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_wrap", a_wrap, 0);
    chk("rst_err", a_err, 0);

    reset = 1'b0;
    tick();
    chk("first_edge_valid", a_valid, 0);
    chk("first_edge_out", a_out, 1);
    tick();
    chk("second_edge_valid", a_valid, 1);

    // Manual jump to channel 5
    a_sel = 3'd5; a_sel_load = 1'b1;
    tick();
    chk("man_cur", a_cur, 5);
    chk("man_valid_drop", a_valid, 0);
    a_sel_load = 1'b0;
    tick();
    chk("man_out", a_out, 6);
    chk("man_valid_back", a_valid, 1);

    a_sel_load = 1'b1;
    tick();
    chk("same_ch_cur", a_cur, 5);
    chk("same_ch_valid", a_valid, 1);

    a_hold = 1'b1; a_sel = 3'd6;
    tick();
    chk("man_hold_jump", a_cur, 6);
    a_sel_load = 1'b0; a_hold = 1'b0;
    tick();

    // Scan from channel 6 with DWELL 3
    a_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("scan_cur_%0d", i), a_cur, exp_cur[i]);
      chk($sformatf("scan_wrap_%0d", i), a_wrap, exp_wrap[i]);
    end

    // Hold at dcnt 1 on channel 0, with d[0] changing underneath
    a_hold = 1'b1; a_d = 32'h8765_432A;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_cur_%0d", i), a_cur, 0);
    end
    chk("hold_out_tracks", a_out, 4'hA);
    a_hold = 1'b0; a_d = 32'h8765_4321;
    tick();
    chk("release_1", a_cur, 0);
    tick();
    chk("release_2", a_cur, 1);

    // Jump beats a same-cycle wrap at dcnt == DWELL-1
    a_sel = 3'd7; a_sel_load = 1'b1;
    tick();
    chk("jump7", a_cur, 7);
    a_sel_load = 1'b0;
    tick(); tick();
    chk("at_tc_cur", a_cur, 7);
    a_sel = 3'd2; a_sel_load = 1'b1;
    tick();
    chk("prio_cur", a_cur, 2);
    chk("prio_wrap", a_wrap, 0);
    a_sel_load = 1'b0;
    tick(); tick();
    chk("prio_dcnt_clr", a_cur, 2);
    tick();
    chk("prio_adv", a_cur, 3);

    // Jump while held, then stay frozen
    a_hold = 1'b1; a_sel = 3'd4; a_sel_load = 1'b1;
    tick();
    chk("hold_jump", a_cur, 4);
    a_sel_load = 1'b0;
    tick(); tick(); tick();
    chk("hold_jump_frozen", a_cur, 4);
    a_hold = 1'b0;
    tick();

    // Reset mid-dwell and mid-jump
    reset = 1'b1; a_sel = 3'd3; a_sel_load = 1'b1;
    tick();
    chk("midrst_cur", a_cur, 0);
    chk("midrst_out", a_out, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_wrap", a_wrap, 0);
    reset = 1'b0; a_sel_load = 1'b0; a_mode = 1'b0;
    tick(); tick();

    // N_CH = 6: out-of-range selects
    b_sel = 3'd7; b_sel_load = 1'b1;
    tick();
    chk("b_err7", b_err, 1);
    chk("b_err7_cur", b_cur, 0);
    chk("b_err7_valid", b_valid, 1);
    b_sel = 3'd6;
    tick();
    chk("b_err6", b_err, 1);
    chk("b_err6_cur", b_cur, 0);
    b_sel = 3'd5;
    tick();
    chk("b_sel5_err", b_err, 0);
    chk("b_sel5_cur", b_cur, 5);
    b_sel_load = 1'b0;
    tick();
    chk("b_err_clear", b_err, 0);

    // DWELL 1 scan: advance every unheld cycle
    b_mode = 1'b1;
    tick();
    chk("b_rise_keep", b_cur, 5);
    tick();
    chk("b_wrap_cur", b_cur, 0);
    chk("b_wrap", b_wrap, 1);
    tick();
    chk("b_adv_cur", b_cur, 1);
    chk("b_adv_wrap", b_wrap, 0);
    chk("b_adv_valid", b_valid, 0);
    b_hold = 1'b1;
    tick();
    chk("b_hold_cur", b_cur, 1);
    b_hold = 1'b0; b_mode = 1'b0;
    tick(); tick();
    chk("b_manual_freeze", b_cur, 1);
    chk("b_manual_valid", b_valid, 1);
    chk("b_manual_out", b_out, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
